// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP configuration-port arbiter: FSM state encoding,
// default register request/response structs and the default watchdog limit.
package rv_iopmp_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int unsigned REG_AW = 32;
  localparam int unsigned REG_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0]   addr;
    logic                write;
    logic [REG_DW-1:0]   wdata;
    logic [REG_DW/8-1:0] wstrb;
    logic                valid;
  } reg_req_default_t;

  typedef struct packed {
    logic [REG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_default_t;

endpackage

// File: rtl/rv_iopmp_rr_pick.sv
// Combinational round-robin search: first set bit of valid_i at or after
// ptr_i, wrapping modulo NUM_REQ.
module rv_iopmp_rr_pick
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (valid_i[cand[IDX_W-1:0]]) begin
        idx_o   = cand[IDX_W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_cfg_arbiter.sv
// Round-robin arbiter sharing the IOPMP configuration register port among NUM_REQ masters.
// Optional downstream-stall watchdog is compiled in with RV_IOPMP_CFG_ARB_TIMEOUT_EN.
module rv_iopmp_cfg_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter type         reg_req_t      = reg_req_default_t,
  parameter type         reg_rsp_t      = reg_rsp_default_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  reg_req_t [NUM_REQ-1:0]     req_i,
  output reg_rsp_t [NUM_REQ-1:0]     rsp_o,
  output reg_req_t                   cfg_req_o,
  input  reg_rsp_t                   cfg_rsp_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       timeout_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               cfg_valid_q;
  logic               dropped_q;
  logic               grantee_valid;
  logic [NUM_REQ-1:0] req_valid;
  reg_rsp_t           rsp_q;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_valid
    assign req_valid[k] = req_i[k].valid;
  end

  rv_iopmp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign grantee_valid = req_i[gnt_idx_q].valid;
  assign rr_ptr_d      = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;
  logic             wd_expired;
  logic             timeout_q;

  assign wd_cnt_d   = wd_cnt_q + CNT_W'(1);
  assign wd_expired = (wd_cnt_d == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      cfg_valid_q <= 1'b0;
      dropped_q   <= 1'b0;
      rsp_q       <= '0;
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      rsp_q.ready <= 1'b0;
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt_idx_q   <= pick_idx;
            cfg_valid_q <= 1'b1;
            dropped_q   <= 1'b0;
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
            wd_cnt_q    <= '0;
`endif
            state_q     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // A withdrawn grantee still lets the downstream access finish; only the reply is dropped.
          if (!grantee_valid) begin
            dropped_q <= 1'b1;
          end
          if (cfg_rsp_i.ready) begin
            rsp_q.rdata <= cfg_rsp_i.rdata;
            rsp_q.error <= cfg_rsp_i.error;
            rsp_q.ready <= grantee_valid & ~dropped_q;
            cfg_valid_q <= 1'b0;
            state_q     <= ARB_RESP;
          end
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            rsp_q.rdata <= '0;
            rsp_q.error <= 1'b1;
            rsp_q.ready <= grantee_valid & ~dropped_q;
            cfg_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= ARB_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
`endif
        end
        ARB_RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_req_o       = req_i[gnt_idx_q];
    cfg_req_o.valid = cfg_valid_q;
  end

  always_comb begin
    rsp_o = '0;
    if (rsp_q.ready) begin
      rsp_o[gnt_idx_q] = rsp_q;
    end
  end

  assign busy_o    = (state_q != ARB_IDLE);
  assign gnt_idx_o = gnt_idx_q;

endmodule

// File: tb/tb_rv_iopmp_cfg_arbiter.sv
// Directed bench for rv_iopmp_cfg_arbiter: transaction-level model checked every
// cycle plus hand-computed latency/ordering expectations.
module tb_rv_iopmp_cfg_arbiter;
  import rv_iopmp_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  reg_req_default_t [NREQ-1:0]  req;
  reg_rsp_default_t [NREQ-1:0]  rsp;
  reg_req_default_t             cfg_req;
  reg_rsp_default_t             cfg_rsp;
  logic                         busy;
  logic [0:0]                   gnt_idx;
  logic                         timeout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rv_iopmp_cfg_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO),
    .reg_req_t      (reg_req_default_t),
    .reg_rsp_t      (reg_rsp_default_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .rsp_o     (rsp),
    .cfg_req_o (cfg_req),
    .cfg_rsp_i (cfg_rsp),
    .busy_o    (busy),
    .gnt_idx_o (gnt_idx),
    .timeout_o (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reg_req_default_t mk_req(input logic [31:0] addr, input logic wr,
                                              input logic [31:0] wdata, input logic [3:0] wstrb);
    reg_req_default_t r;
    r.addr  = addr;
    r.write = wr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    r.valid = 1'b1;
    return r;
  endfunction

  // Transaction model: phase 0 = no transaction, 1 = waiting on register file,
  // 2 = reply slot. Updated from the inputs only.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_gnt   = 0;
  int          m_wait  = 0;
  bit          m_lost  = 0;
  bit          m_deliver = 0;
  bit          m_tmo   = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err   = 0;

  always @(posedge clk) begin
    int cand;
    bit found;
    found = 0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gnt = 0; m_rdata = '0; m_err = 0; m_deliver = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      if (m_phase == 2) begin
        m_ptr     = (m_gnt + 1) % NREQ;
        m_phase   = 0;
        m_deliver = 0;
      end else if (m_phase == 1) begin
        if (!req[m_gnt].valid) m_lost = 1;
        if (cfg_rsp.ready) begin
          m_rdata = cfg_rsp.rdata; m_err = cfg_rsp.error; m_deliver = !m_lost; m_phase = 2;
        end else begin
          m_wait++;
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
          if (m_wait == TMO) begin
            m_rdata = '0; m_err = 1; m_deliver = !m_lost; m_tmo = 1; m_phase = 2;
          end
`endif
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          cand = (m_ptr + k) % NREQ;
          if (!found && req[cand].valid) begin
            found = 1;
            m_gnt = cand;
          end
        end
        if (found) begin
          m_phase = 1; m_lost = 0; m_wait = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit hit;
    check("busy", busy, 32'(m_phase != 0));
    check("gnt_idx", 32'(gnt_idx), 32'(m_gnt));
    check("cfg_valid", cfg_req.valid, 32'(m_phase == 1));
    if (m_phase == 1) begin
      check("cfg_addr", cfg_req.addr, req[m_gnt].addr);
      check("cfg_write", cfg_req.write, req[m_gnt].write);
      check("cfg_wdata", cfg_req.wdata, req[m_gnt].wdata);
      check("cfg_wstrb", 32'(cfg_req.wstrb), 32'(req[m_gnt].wstrb));
    end
    for (int k = 0; k < NREQ; k++) begin
      hit = (m_phase == 2) && m_deliver && (k == m_gnt);
      check($sformatf("rsp%0d_ready", k), rsp[k].ready, 32'(hit));
      check($sformatf("rsp%0d_error", k), rsp[k].error, hit ? 32'(m_err) : 32'd0);
      check($sformatf("rsp%0d_rdata", k), rsp[k].rdata, hit ? m_rdata : 32'd0);
    end
    check("timeout", timeout, 32'(m_tmo));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int exp_order[4];
    int lat;
    int first;
    int t_at;
    int r_at;
    exp_order = '{0, 1, 0, 1};
    rst     = 1'b1;
    req     = '0;
    cfg_rsp = '0;
    step();
    step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cfg_valid", cfg_req.valid, 0);
    check("rst_gnt", 32'(gnt_idx), 0);
    check("rst_rsp0_ready", rsp[0].ready, 0);
    check("rst_timeout", timeout, 0);
    step();
    rst = 1'b0;
    step();

    // Single write, downstream ready at once
    req[0]  = mk_req(32'h010, 1'b1, 32'h1, 4'hf);
    cfg_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    @(negedge clk); check("single_c0_valid", cfg_req.valid, 0);
    @(negedge clk); check("single_c1_valid", cfg_req.valid, 1);
                    check("single_c1_addr", cfg_req.addr, 32'h010);
    @(negedge clk); check("single_c2_valid", cfg_req.valid, 0);
                    check("single_c2_ready", rsp[0].ready, 1);
                    check("single_c2_error", rsp[0].error, 0);
    step();
    req[0].valid = 1'b0;
    @(negedge clk); check("single_c3_ready", rsp[0].ready, 0);
    step();
    step();

    // Contention from reset: expect 0,1,0,1
    do_reset();
    req[0]  = mk_req(32'h100, 1'b0, 32'h0, 4'h0);
    req[1]  = mk_req(32'h104, 1'b0, 32'h0, 4'h0);
    cfg_rsp = '{rdata: 32'h1234_5678, error: 1'b0, ready: 1'b1};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) if (rsp[k].ready) order.push_back(k);
    end
    step();
    req[0].valid = 1'b0;
    req[1].valid = 1'b0;
    check("cont_count", 32'(order.size()), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      check($sformatf("cont_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Downstream stall of 5 cycles on a read
    step();
    req[0]  = mk_req(32'h020, 1'b0, 32'h0, 4'h0);
    cfg_rsp = '{rdata: 32'hDEAD_BEEF, error: 1'b0, ready: 1'b0};
    lat = -1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (cfg_req.valid) check("stall_addr", cfg_req.addr, 32'h020);
      if (rsp[0].ready) begin
        lat = c;
        check("stall_rdata", rsp[0].rdata, 32'hDEAD_BEEF);
      end else begin
        step();
        if (c == 5) cfg_rsp.ready = 1'b1;
      end
    end
    check("stall_latency", 32'(lat), 7);
    step();
    req[0].valid  = 1'b0;
    cfg_rsp.ready = 1'b0;

    // Withdrawal during BUSY: reply discarded, pointer still moves on
    do_reset();
    req[0]  = mk_req(32'h030, 1'b0, 32'h0, 4'h0);
    cfg_rsp = '{rdata: 32'h0000_0055, error: 1'b0, ready: 1'b0};
    first = -1;
    lat   = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) if (rsp[k].ready && first < 0) begin first = k; lat = c; end
      if (first < 0) begin
        step();
        if (c == 0) req[0].valid = 1'b0;
        if (c == 1) begin
          cfg_rsp.ready = 1'b1;
          req[0].valid  = 1'b1;
          req[1]        = mk_req(32'h034, 1'b0, 32'h0, 4'h0);
        end
      end
    end
    check("wd_first_grantee", 32'(first), 1);
    check("wd_latency", 32'(lat), 6);
    step();
    req[0].valid = 1'b0;
    req[1].valid = 1'b0;
    step();

    // Reset in the middle of BUSY
    req[1]        = mk_req(32'h040, 1'b1, 32'hCAFE_0001, 4'h3);
    cfg_rsp.ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy_pre", busy, 1);
    check("mid_valid_pre", cfg_req.valid, 1);
    check("mid_gnt_pre", 32'(gnt_idx), 1);
    step();
    rst           = 1'b0;
    req[0]        = mk_req(32'h044, 1'b0, 32'h0, 4'h0);
    cfg_rsp.ready = 1'b1;
    @(negedge clk);
    check("mid_valid_post", cfg_req.valid, 0);
    check("mid_busy_post", busy, 0);
    check("mid_gnt_post", 32'(gnt_idx), 0);
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      step();
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) if (rsp[k].ready && first < 0) first = k;
    end
    check("mid_first_after_rst", 32'(first), 0);
    step();
    req[0].valid = 1'b0;
    req[1].valid = 1'b0;
    step();
    step();

    // Downstream never answers
    req[1]  = mk_req(32'h050, 1'b0, 32'h0, 4'h0);
    cfg_rsp = '{rdata: 32'h0BAD_F00D, error: 1'b1, ready: 1'b0};
    t_at = -1;
    r_at = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (timeout && t_at < 0) t_at = c;
      if (rsp[1].ready && r_at < 0) begin
        r_at = c;
        check("tmo_error", rsp[1].error, 1);
        check("tmo_rdata", rsp[1].rdata, 0);
      end
      step();
      if (r_at >= 0) req[1].valid = 1'b0;
    end
`ifdef RV_IOPMP_CFG_ARB_TIMEOUT_EN
    check("tmo_pulse_cycle", 32'(t_at), 9);
    check("tmo_rsp_cycle", 32'(r_at), 9);
`else
    check("hang_no_timeout", 32'(t_at), 32'hFFFF_FFFF);
    check("hang_no_rsp", 32'(r_at), 32'hFFFF_FFFF);
    @(negedge clk);
    check("hang_busy", busy, 1);
    step();
    cfg_rsp.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hang_release_ready", rsp[1].ready, 1);
    check("hang_release_error", rsp[1].error, 1);
    check("hang_release_rdata", rsp[1].rdata, 32'h0BAD_F00D);
    step();
    req[1].valid = 1'b0;
`endif
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
